// File: rtl/hd_transfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hd_transfer_ctrl                                             |
// | Description : Word-by-word block copy between disk and main memory.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hd_transfer_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 13,
    parameter int DISK_SIZE   = 4096,
    parameter int MEM_SIZE    = 32768
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   dir,
    input  logic [ADDR_WIDTH-1:0]  hd_base,
    input  logic [ADDR_WIDTH-1:0]  mem_base,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic [ADDR_WIDTH-1:0]  hd_address,
    output logic                   hd_write_flag,
    output logic [DATA_WIDTH-1:0]  hd_input_data,
    input  logic [DATA_WIDTH-1:0]  hd_output,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic                   mem_write_flag,
    output logic [DATA_WIDTH-1:0]  mem_write_data,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_check = 3'd1;
    localparam logic [2:0] c_st_rd    = 3'd2;
    localparam logic [2:0] c_st_wt    = 3'd3;
    localparam logic [2:0] c_st_wr    = 3'd4;
    localparam logic [2:0] c_st_fin   = 3'd5;

    localparam logic [ADDR_WIDTH:0] c_disk_size = (ADDR_WIDTH+1)'(DISK_SIZE);
    localparam logic [ADDR_WIDTH:0] c_mem_size  = (ADDR_WIDTH+1)'(MEM_SIZE);

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic                   r_dir;
    logic                   r_err;
    logic [ADDR_WIDTH-1:0]  r_hd_base;
    logic [ADDR_WIDTH-1:0]  r_mem_base;
    logic [ADDR_WIDTH-1:0]  r_hd_addr_hold;
    logic [ADDR_WIDTH-1:0]  r_mem_addr_hold;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_index;
    logic [DATA_WIDTH-1:0]  r_data_q;

    logic [ADDR_WIDTH-1:0]  w_index_ext;
    logic [ADDR_WIDTH-1:0]  w_hd_addr;
    logic [ADDR_WIDTH-1:0]  w_mem_addr;
    logic [ADDR_WIDTH:0]    w_count_ext;
    logic [ADDR_WIDTH:0]    w_hd_end;
    logic [ADDR_WIDTH:0]    w_mem_end;
    logic                   w_reject;
    logic                   w_last;
    logic                   w_hd_drive;
    logic                   w_mem_drive;

    assign w_index_ext = ADDR_WIDTH'(r_index);
    assign w_hd_addr   = r_hd_base + w_index_ext;
    assign w_mem_addr  = r_mem_base + w_index_ext;
    assign w_count_ext = (ADDR_WIDTH+1)'(r_count);

    // One extra bit so a base near the top of the address space cannot wrap into range.
    assign w_hd_end  = {1'b0, r_hd_base} + w_count_ext;
    assign w_mem_end = {1'b0, r_mem_base} + w_count_ext;
    assign w_reject  = (r_count == '0) || (w_hd_end > c_disk_size) || (w_mem_end > c_mem_size);
    assign w_last    = ((r_index + COUNT_WIDTH'(1)) == r_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  w_next = start ? c_st_check : c_st_idle;
            c_st_check: w_next = w_reject ? c_st_fin : c_st_rd;
            c_st_rd:    w_next = c_st_wt;
            c_st_wt:    w_next = c_st_wr;
            c_st_wr:    w_next = w_last ? c_st_fin : c_st_rd;
            c_st_fin:   w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy           = (r_state == c_st_check) || (r_state == c_st_rd) ||
                         (r_state == c_st_wt)    || (r_state == c_st_wr);
        done           = (r_state == c_st_fin);
        error          = (r_state == c_st_fin) && r_err;
        hd_write_flag  = (r_state == c_st_wr) && r_dir;
        mem_write_flag = (r_state == c_st_wr) && !r_dir;
        w_hd_drive     = ((r_state == c_st_rd) && !r_dir) || ((r_state == c_st_wr) && r_dir);
        w_mem_drive    = ((r_state == c_st_rd) && r_dir)  || ((r_state == c_st_wr) && !r_dir);
        hd_address     = w_hd_drive  ? w_hd_addr  : r_hd_addr_hold;
        mem_address    = w_mem_drive ? w_mem_addr : r_mem_addr_hold;
        hd_input_data  = r_data_q;
        mem_write_data = r_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir           <= 1'b0;
            r_err           <= 1'b0;
            r_hd_base       <= '0;
            r_mem_base      <= '0;
            r_count         <= '0;
            r_index         <= '0;
            r_data_q        <= '0;
            r_hd_addr_hold  <= '0;
            r_mem_addr_hold <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_dir      <= dir;
                        r_hd_base  <= hd_base;
                        r_mem_base <= mem_base;
                        r_count    <= word_count;
                        r_index    <= '0;
                        r_err      <= 1'b0;
                    end
                end
                c_st_check: r_err    <= w_reject;
                c_st_wt:    r_data_q <= r_dir ? mem_read_data : hd_output;
                c_st_wr:    r_index  <= r_index + COUNT_WIDTH'(1);
                default:    ;
            endcase
            // Addresses hold their last driven value between accesses.
            if (w_hd_drive) begin
                r_hd_addr_hold <= w_hd_addr;
            end
            if (w_mem_drive) begin
                r_mem_addr_hold <= w_mem_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hd_transfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hd_transfer_ctrl                                          |
// | Description : Directed scoreboard bench with disk and memory models.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_hd_transfer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] hd_base = '0;
    logic [31:0] mem_base = '0;
    logic [12:0] word_count = '0;
    logic [31:0] hd_address;
    logic        hd_write_flag;
    logic [31:0] hd_input_data;
    logic [31:0] hd_output = '0;
    logic [31:0] mem_address;
    logic        mem_write_flag;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        busy;
    logic        done;
    logic        error;

    hd_transfer_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .dir            (dir),
        .hd_base        (hd_base),
        .mem_base       (mem_base),
        .word_count     (word_count),
        .hd_address     (hd_address),
        .hd_write_flag  (hd_write_flag),
        .hd_input_data  (hd_input_data),
        .hd_output      (hd_output),
        .mem_address    (mem_address),
        .mem_write_flag (mem_write_flag),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Storage is pattern XOR delta so the model arrays have a single writer.
    bit [31:0] hd_dlt  [4096];
    bit [31:0] mem_dlt [32768];

    function automatic logic [31:0] hd_pat(input int a);
        return 32'hD15C_0000 + 32'(a) * 32'd3;
    endfunction
    function automatic logic [31:0] mem_pat(input int a);
        return 32'h3E30_0000 + 32'(a) * 32'd5;
    endfunction
    function automatic logic [31:0] hd_val(input int a);
        return hd_pat(a) ^ hd_dlt[a];
    endfunction
    function automatic logic [31:0] mem_val(input int a);
        return mem_pat(a) ^ mem_dlt[a];
    endfunction

    always @(posedge clk) begin
        hd_output     <= hd_val(int'(hd_address[11:0]));
        mem_read_data <= mem_val(int'(mem_address[14:0]));
        if (hd_write_flag)
            hd_dlt[hd_address[11:0]] <= hd_input_data ^ hd_pat(int'(hd_address[11:0]));
        if (mem_write_flag)
            mem_dlt[mem_address[14:0]] <= mem_write_data ^ mem_pat(int'(mem_address[14:0]));
    end

    typedef struct {
        bit          to_hd;
        logic [31:0] addr;
        logic [31:0] data;
        int          rel;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int base_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (!reset) begin
            if (done) n_done++;
            if (hd_write_flag && mem_write_flag) chk("both_wflags", 1, 0);
            if (hd_write_flag || mem_write_flag) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {32'd0, hd_write_flag ? hd_address : mem_address}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_side",  {63'd0, hd_write_flag}, {63'd0, e.to_hd});
                    chk("wr_addr",  {32'd0, hd_write_flag ? hd_address : mem_address}, {32'd0, e.addr});
                    chk("wr_data",  {32'd0, hd_write_flag ? hd_input_data : mem_write_data}, {32'd0, e.data});
                    chk("wr_cycle", 64'(cyc - base_cyc + 1), 64'(e.rel));
                end
            end
        end
    end

    task automatic push_xfer(input bit d, input int hb, input int mb, input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.to_hd = d;
            e.addr  = d ? 32'(hb + k) : 32'(mb + k);
            e.data  = d ? mem_val(mb + k) : hd_val(hb + k);
            e.rel   = 4 + 3 * k;
            exp_q.push_back(e);
        end
    endtask

    // Returns at the negedge of cycle 1; inputs are scrambled after acceptance.
    task automatic do_start(input bit d, input int hb, input int mb, input int n);
        @(negedge clk);
        dir        = d;
        hd_base    = 32'(hb);
        mem_base   = 32'(mb);
        word_count = 13'(n);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        base_cyc   = cyc;
        dir        = ~d;
        hd_base    = 32'h0000_0123;
        mem_base   = 32'h0000_4567;
        word_count = 13'd7;
    endtask

    task automatic wait_done(input string tag, input int exp_rel, input bit exp_err);
        int t = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        chk({tag, "_done_cycle"}, 64'(cyc - base_cyc + 1), 64'(exp_rel));
        chk({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
        chk({tag, "_busy_fin"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_all_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        logic [31:0] x0;
        logic [31:0] y0;

        #1 reset = 1'b1;
        #2;
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_done",     {63'd0, done}, 64'd0);
        chk("rst_error",    {63'd0, error}, 64'd0);
        chk("rst_hd_wf",    {63'd0, hd_write_flag}, 64'd0);
        chk("rst_mem_wf",   {63'd0, mem_write_flag}, 64'd0);
        chk("rst_hd_addr",  {32'd0, hd_address}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_address}, 64'd0);
        chk("rst_hd_data",  {32'd0, hd_input_data}, 64'd0);
        chk("rst_mem_data", {32'd0, mem_write_data}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Load: disk 10..13 -> memory 2048..2051.
        push_xfer(1'b0, 10, 2048, 4);
        do_start(1'b0, 10, 2048, 4);
        chk("load_busy", {63'd0, busy}, 64'd1);
        wait_done("load", 14, 1'b0);
        for (int k = 0; k < 4; k++) chk("load_mem", {32'd0, mem_val(2048 + k)}, {32'd0, hd_pat(10 + k)});

        // Store: memory 100..101 -> disk 4000..4001.
        x0 = mem_val(100);
        y0 = mem_val(101);
        push_xfer(1'b1, 4000, 100, 2);
        do_start(1'b1, 4000, 100, 2);
        wait_done("store", 8, 1'b0);
        chk("store_hd0", {32'd0, hd_val(4000)}, {32'd0, x0});
        chk("store_hd1", {32'd0, hd_val(4001)}, {32'd0, y0});

        // Rejections.
        do_start(1'b0, 0, 0, 0);
        wait_done("rej_zero", 2, 1'b1);
        do_start(1'b1, 4095, 0, 2);
        wait_done("rej_disk", 2, 1'b1);
        chk("rej_disk_hd", {32'd0, hd_val(4095)}, {32'd0, hd_pat(4095)});
        do_start(1'b0, 0, 32767, 2);
        wait_done("rej_mem", 2, 1'b1);

        // Second start while busy is ignored.
        d0 = n_done;
        push_xfer(1'b0, 20, 3000, 4);
        do_start(1'b0, 20, 3000, 4);
        repeat (4) @(negedge clk);
        dir = 1'b1; hd_base = 32'd700; mem_base = 32'd7000; word_count = 13'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign", 14, 1'b0);
        repeat (10) @(negedge clk);
        chk("busy_ign_idle", {63'd0, busy}, 64'd0);
        chk("busy_ign_ndone", 64'(n_done - d0), 64'd1);

        // Reset in WT of the third word: two words land, no done.
        d0 = n_done;
        push_xfer(1'b0, 40, 5000, 2);
        do_start(1'b0, 40, 5000, 4);
        repeat (8) @(negedge clk);
        chk("rstmid_busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_busy",     {63'd0, busy}, 64'd0);
        chk("rstmid_done",     {63'd0, done}, 64'd0);
        chk("rstmid_mem_wf",   {63'd0, mem_write_flag}, 64'd0);
        chk("rstmid_hd_addr",  {32'd0, hd_address}, 64'd0);
        chk("rstmid_mem_addr", {32'd0, mem_address}, 64'd0);
        chk("rstmid_data",     {32'd0, mem_write_data}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_nwrites", 64'(exp_q.size()), 64'd0);
        chk("rstmid_ndone",   64'(n_done - d0), 64'd0);
        chk("rstmid_mem2",    {32'd0, mem_val(5002)}, {32'd0, mem_pat(5002)});
        push_xfer(1'b0, 40, 5000, 4);
        do_start(1'b0, 40, 5000, 4);
        wait_done("rstmid_redo", 14, 1'b0);
        chk("rstmid_redo_mem3", {32'd0, mem_val(5003)}, {32'd0, hd_pat(43)});

        // Exactly reaching the end of the disk is accepted.
        push_xfer(1'b0, 4092, 600, 4);
        do_start(1'b0, 4092, 600, 4);
        wait_done("bound", 14, 1'b0);
        chk("bound_mem3", {32'd0, mem_val(603)}, {32'd0, hd_pat(4095)});

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
